pd_power_sequencer: RTL and testbench

//  Sequences one switchable power domain, e.g. the design_top switched

---
 rtl/pd_seq_pkg.sv | 84 ++++++++
 rtl/pd_seq_timer.sv | 35 +++
 rtl/pd_power_sequencer.sv | 150 +++++++++++++++
 tb/tb_pd_power_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pd_seq_pkg.sv
// Shared types and defaults for the power-domain sequencer.
// PSEQ_RETENTION_EN enables the retention save/restore strobes in the output decode.
package pd_seq_pkg;

  localparam int PSEQ_ISO_SETTLE  = 4;
  localparam int PSEQ_RET_CYC     = 2;
  localparam int PSEQ_ACK_TIMEOUT = 64;

  typedef enum logic [3:0] {
    ST_OFF     = 4'd0,
    ST_SW_ON   = 4'd1,
    ST_RESTORE = 4'd2,
    ST_ISO_OFF = 4'd3,
    ST_ON      = 4'd4,
    ST_ISO_ON  = 4'd5,
    ST_SAVE    = 4'd6,
    ST_SW_OFF  = 4'd7,
    ST_ERR     = 4'd8
  } pseq_state_e;

  typedef struct packed {
    logic pwr_sw_en;
    logic iso_en;
    logic ret_save;
    logic ret_restore;
    logic pwr_on;
    logic busy;
    logic err;
  } pseq_out_t;

  function automatic pseq_out_t pseq_decode(input pseq_state_e st);
    pseq_out_t o;
    o.pwr_sw_en   = 1'b0;
    o.iso_en      = 1'b1;
    o.ret_save    = 1'b0;
    o.ret_restore = 1'b0;
    o.pwr_on      = 1'b0;
    o.busy        = 1'b0;
    o.err         = 1'b0;
    case (st)
      ST_OFF: begin
        o.busy = 1'b0;
      end
      ST_SW_ON, ST_ISO_OFF, ST_ISO_ON: begin
        o.pwr_sw_en = 1'b1;
        o.busy      = 1'b1;
      end
      ST_RESTORE: begin
        o.pwr_sw_en = 1'b1;
        o.busy      = 1'b1;
`ifdef PSEQ_RETENTION_EN
        o.ret_restore = 1'b1;
`else
        o.ret_restore = 1'b0;
`endif
      end
      ST_SAVE: begin
        o.pwr_sw_en = 1'b1;
        o.busy      = 1'b1;
`ifdef PSEQ_RETENTION_EN
        o.ret_save = 1'b1;
`else
        o.ret_save = 1'b0;
`endif
      end
      ST_ON: begin
        o.pwr_sw_en = 1'b1;
        o.iso_en    = 1'b0;
        o.pwr_on    = 1'b1;
      end
      ST_SW_OFF: begin
        o.busy = 1'b1;
      end
      ST_ERR: begin
        o.err = 1'b1;
      end
      default: begin
        o.err = 1'b1;
      end
    endcase
    return o;
  endfunction

endpackage

// File: rtl/pd_seq_timer.sv
// Saturating step timer for the power sequencer: sync clear on state entry,
// flags expiry when the count reaches LIMIT.
module pd_seq_timer #(
  parameter int LIMIT = 64,
  parameter int CNT_W = $clog2(LIMIT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             expire
);

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;

  // count up from zero, hold at LIMIT, restart on clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_r != LIMIT_C) begin
      cnt_r <= cnt_r + ONE_C;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt    = cnt_r;
  assign expire = (cnt_r == LIMIT_C);

endmodule

// File: rtl/pd_power_sequencer.sv
// Power-domain sequencer: switch enable, isolation and retention strobes in order,
// with switch-ack timeout. PSEQ_RETENTION_EN adds the save/restore steps.
module pd_power_sequencer
  import pd_seq_pkg::*;
#(
  parameter int ISO_SETTLE  = PSEQ_ISO_SETTLE,
  parameter int RET_CYC     = PSEQ_RET_CYC,
  parameter int ACK_TIMEOUT = PSEQ_ACK_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pwr_down_req,
  input  logic pwr_up_req,
  input  logic pwr_sw_ack,
  input  logic err_clr,
  output logic pwr_sw_en,
  output logic iso_en,
  output logic ret_save,
  output logic ret_restore,
  output logic pwr_on,
  output logic busy,
  output logic err
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] ISO_LAST = CNT_W'(ISO_SETTLE - 1);
  localparam logic [CNT_W-1:0] RET_LAST = CNT_W'(RET_CYC - 1);

`ifdef PSEQ_RETENTION_EN
  localparam pseq_state_e AFTER_SW_ON  = ST_RESTORE;
  localparam pseq_state_e AFTER_ISO_ON = ST_SAVE;
`else
  localparam pseq_state_e AFTER_SW_ON  = ST_ISO_OFF;
  localparam pseq_state_e AFTER_ISO_ON = ST_SW_OFF;
`endif

  pseq_state_e      state_r;
  pseq_state_e      state_nxt_s;
  pseq_out_t        out_nxt_s;
  logic [CNT_W-1:0] cnt_s;
  logic [CNT_W-1:0] hold_last_s;
  logic             hold_done_s;
  logic             timeout_s;
  logic             tmr_clr_s;

  // timer restarts whenever the state is about to change
  assign tmr_clr_s = (state_nxt_s != state_r);

  pd_seq_timer #(
    .LIMIT (ACK_TIMEOUT),
    .CNT_W (CNT_W)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (tmr_clr_s),
    .cnt    (cnt_s),
    .expire (timeout_s)
  );

  // select the last timer value of the current hold step
  always_comb begin
    hold_last_s = ISO_LAST;
    if ((state_r == ST_SAVE) || (state_r == ST_RESTORE)) begin
      hold_last_s = RET_LAST;
    end else begin
      hold_last_s = ISO_LAST;
    end
    hold_done_s = (cnt_s == hold_last_s);
  end

  // next-state logic; requests are only looked at in the two stable states
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_OFF: begin
        if (pwr_up_req) state_nxt_s = ST_SW_ON;
        else            state_nxt_s = ST_OFF;
      end
      ST_SW_ON: begin
        if (pwr_sw_ack)     state_nxt_s = AFTER_SW_ON;
        else if (timeout_s) state_nxt_s = ST_ERR;
        else                state_nxt_s = ST_SW_ON;
      end
`ifdef PSEQ_RETENTION_EN
      ST_RESTORE: begin
        if (hold_done_s) state_nxt_s = ST_ISO_OFF;
        else             state_nxt_s = ST_RESTORE;
      end
      ST_SAVE: begin
        if (hold_done_s) state_nxt_s = ST_SW_OFF;
        else             state_nxt_s = ST_SAVE;
      end
`endif
      ST_ISO_OFF: begin
        if (hold_done_s) state_nxt_s = ST_ON;
        else             state_nxt_s = ST_ISO_OFF;
      end
      ST_ON: begin
        if (pwr_down_req) state_nxt_s = ST_ISO_ON;
        else              state_nxt_s = ST_ON;
      end
      ST_ISO_ON: begin
        if (hold_done_s) state_nxt_s = AFTER_ISO_ON;
        else             state_nxt_s = ST_ISO_ON;
      end
      ST_SW_OFF: begin
        if (!pwr_sw_ack)    state_nxt_s = ST_OFF;
        else if (timeout_s) state_nxt_s = ST_ERR;
        else                state_nxt_s = ST_SW_OFF;
      end
      ST_ERR: begin
        if (err_clr) state_nxt_s = ST_OFF;
        else         state_nxt_s = ST_ERR;
      end
      // unreachable encodings fall into the safe error state
      default: begin
        state_nxt_s = ST_ERR;
      end
    endcase
  end

  // outputs are decoded from the next state so they move with the state register
  always_comb begin
    out_nxt_s = pseq_decode(state_nxt_s);
  end

  // state and registered outputs, async reset to the safe powered-off values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_OFF;
      pwr_sw_en   <= 1'b0;
      iso_en      <= 1'b1;
      ret_save    <= 1'b0;
      ret_restore <= 1'b0;
      pwr_on      <= 1'b0;
      busy        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      pwr_sw_en   <= out_nxt_s.pwr_sw_en;
      iso_en      <= out_nxt_s.iso_en;
      ret_save    <= out_nxt_s.ret_save;
      ret_restore <= out_nxt_s.ret_restore;
      pwr_on      <= out_nxt_s.pwr_on;
      busy        <= out_nxt_s.busy;
      err         <= out_nxt_s.err;
    end
  end

endmodule

// File: tb/tb_pd_power_sequencer.sv
// Directed bench for pd_power_sequencer: per-cycle vector table plus hand-written
// timeout and mid-sequence reset sequences. Expectations follow PSEQ_RETENTION_EN.
module tb_pd_power_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  logic pwr_down_req, pwr_up_req, pwr_sw_ack, err_clr;
  logic pwr_sw_en, iso_en, ret_save, ret_restore, pwr_on, busy, err;

  // observed outputs packed as {sw_en, iso, save, restore, on, busy, err}
  localparam logic [6:0] O_OFF  = 7'b0100000;
  localparam logic [6:0] O_BUSY = 7'b1100010;
  localparam logic [6:0] O_REST = 7'b1101010;
  localparam logic [6:0] O_SAVE = 7'b1110010;
  localparam logic [6:0] O_ON   = 7'b1000100;
  localparam logic [6:0] O_SWOF = 7'b0100010;
  localparam logic [6:0] O_ERR  = 7'b0100001;

  typedef struct packed {
    logic       up;
    logic       down;
    logic       ack;
    logic       clr;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;
  logic [6:0] obs;

  assign obs = {pwr_sw_en, iso_en, ret_save, ret_restore, pwr_on, busy, err};

  pd_power_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pwr_down_req (pwr_down_req),
    .pwr_up_req   (pwr_up_req),
    .pwr_sw_ack   (pwr_sw_ack),
    .err_clr      (err_clr),
    .pwr_sw_en    (pwr_sw_en),
    .iso_en       (iso_en),
    .ret_save     (ret_save),
    .ret_restore  (ret_restore),
    .pwr_on       (pwr_on),
    .busy         (busy),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [6:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b", name, obs, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic add(input logic u, input logic d, input logic a, input logic c,
                     input logic [6:0] e);
    vec_t v;
    v.up = u; v.down = d; v.ack = a; v.clr = c; v.exp = e;
    tbl.push_back(v);
  endtask

  // ISO_OFF hold: 3 cycles holding, release to ON on the 4th
  task automatic add_iso_release();
    for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 1'b1, 1'b0, O_BUSY);
    add(1'b0, 1'b0, 1'b1, 1'b0, O_ON);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    pwr_down_req = 1'b0; pwr_up_req = 1'b0; pwr_sw_ack = 1'b0; err_clr = 1'b0;

    // ---- vector table ----
    // power up, ack arrives 3 cycles after pwr_sw_en
    add(1'b1, 1'b0, 1'b0, 1'b0, O_BUSY);
    for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 1'b0, 1'b0, O_BUSY);
`ifdef PSEQ_RETENTION_EN
    add(1'b0, 1'b0, 1'b1, 1'b0, O_REST);
    add(1'b0, 1'b0, 1'b1, 1'b0, O_REST);
    add(1'b0, 1'b0, 1'b1, 1'b0, O_BUSY);
`else
    add(1'b0, 1'b0, 1'b1, 1'b0, O_BUSY);
`endif
    add_iso_release();
    add(1'b0, 1'b0, 1'b1, 1'b0, O_ON);
    add(1'b0, 1'b0, 1'b1, 1'b0, O_ON);
    // power down; down_req held through busy has no extra effect
    add(1'b0, 1'b1, 1'b1, 1'b0, O_BUSY);
    for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 1'b1, 1'b0, O_BUSY);
`ifdef PSEQ_RETENTION_EN
    add(1'b0, 1'b0, 1'b1, 1'b0, O_SAVE);
    add(1'b0, 1'b0, 1'b1, 1'b0, O_SAVE);
`endif
    add(1'b0, 1'b0, 1'b1, 1'b0, O_SWOF);
    add(1'b0, 1'b0, 1'b1, 1'b0, O_SWOF);
    add(1'b0, 1'b0, 1'b0, 1'b0, O_OFF);
    add(1'b0, 1'b0, 1'b0, 1'b0, O_OFF);
    // ack already high on entry to SW_ON: single wait cycle
    add(1'b0, 1'b0, 1'b1, 1'b0, O_OFF);
    add(1'b1, 1'b0, 1'b1, 1'b0, O_BUSY);
`ifdef PSEQ_RETENTION_EN
    add(1'b0, 1'b0, 1'b1, 1'b0, O_REST);
    add(1'b0, 1'b0, 1'b1, 1'b0, O_REST);
    add(1'b0, 1'b0, 1'b1, 1'b0, O_BUSY);
`else
    add(1'b0, 1'b0, 1'b1, 1'b0, O_BUSY);
`endif
    add_iso_release();
    // both requests in ON: only down acts; up toggled during busy ignored
    add(1'b1, 1'b1, 1'b1, 1'b0, O_BUSY);
    add(1'b0, 1'b0, 1'b1, 1'b0, O_BUSY);
    add(1'b1, 1'b0, 1'b1, 1'b0, O_BUSY);
    add(1'b0, 1'b0, 1'b1, 1'b0, O_BUSY);
`ifdef PSEQ_RETENTION_EN
    add(1'b1, 1'b0, 1'b1, 1'b0, O_SAVE);
`else
    add(1'b1, 1'b0, 1'b1, 1'b0, O_SWOF);
`endif

    // ---- reset state and idle ----
    step();
    check("reset", O_OFF);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("idle%0d", i), O_OFF);
    end

    // ---- apply vector table ----
    for (int i = 0; i < tbl.size(); i++) begin
      pwr_up_req   = tbl[i].up;
      pwr_down_req = tbl[i].down;
      pwr_sw_ack   = tbl[i].ack;
      err_clr      = tbl[i].clr;
      step();
      check($sformatf("vec%0d", i), tbl[i].exp);
    end

    // ---- async reset mid power-down (in SAVE, or SW_OFF without retention) ----
    pwr_up_req = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", O_OFF);
    pwr_sw_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst", O_OFF);

    // ---- ack timeout in SW_ON ----
    pwr_up_req = 1'b1;
    step();
    check("to_enter", O_BUSY);
    pwr_up_req = 1'b0;
    n = 0;
    for (int k = 1; k <= 200; k++) begin
      step();
      if (err === 1'b1) begin
        n = k;
        break;
      end
    end
    check_int("to_cycles", n, 65);
    check("to_err", O_ERR);
    pwr_up_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("err_hold%0d", i), O_ERR);
    end
    pwr_up_req = 1'b0;
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("err_clr", O_OFF);
    step();
    check("err_clr_off", O_OFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
